seedgen_lfsr: RTL



---
 rtl/seedgen_pkg.sv | 30 +++
 rtl/seedgen_basis.sv | 43 ++++
 rtl/seedgen_lfsr.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seedgen_pkg.sv
// ============================================================================
// Module   : seedgen_pkg
// Brief    : Shared state encoding, default Galois taps and the LFSR step
//            function for the seed generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seedgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0]  c_TAPS_W8  = 8'hB8;
    localparam logic [15:0] c_TAPS_W16 = 16'hB400;
    localparam logic [31:0] c_TAPS_W32 = 32'h8020_0003;
    localparam logic [63:0] c_TAPS_W64 = 64'hD800_0000_0000_0000;

    // Operands are zero-extended to 64 bits; narrower callers truncate the result.
    function automatic logic [63:0] lfsr_step(input logic [63:0] value,
                                              input logic [63:0] taps);
        return (value >> 1) ^ (value[0] ? taps : 64'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seedgen_basis.sv
// ============================================================================
// Module   : seedgen_basis
// Brief    : Free-running WIDTH-bit basis counter with sticky wrap flag and
//            synchronous restart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seedgen_basis #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    output logic [WIDTH-1:0] basis,
    output logic             rollover
);

    logic [WIDTH-1:0] r_basis;
    logic             r_rollover;

    // Restart outranks a coincident wrap, so rollover stays clear in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_basis    <= '0;
            r_rollover <= 1'b0;
        end else if (restart) begin
            r_basis    <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_basis <= r_basis + 1'b1;
            if (&r_basis) begin
                r_rollover <= 1'b1;
            end
        end
    end

    assign basis    = r_basis;
    assign rollover = r_rollover;

endmodule

`default_nettype wire

// File: rtl/seedgen_lfsr.sv
// ============================================================================
// Module   : seedgen_lfsr
// Brief    : Captures the basis counter on request, whitens it with MIX_ROUNDS
//            Galois LFSR steps and offers it over a valid/ack handshake.
//            Optional SEEDGEN_ENTROPY_EN mixes a synchronised entropy_in bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seedgen_lfsr
    import seedgen_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter logic [63:0] TAPS         = 64'h8020_0003,
    parameter int          MIX_ROUNDS   = 8,
    parameter logic [63:0] NONZERO_SEED = 64'hACE1_ACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rst_seedgen,
    input  logic             seed_req,
    input  logic             seed_ack,
`ifdef SEEDGEN_ENTROPY_EN
    input  logic             entropy_in,
`endif
    output logic [WIDTH-1:0] seed,
    output logic             seed_valid,
    output logic             busy,
    output logic             rollover
);

    localparam logic [WIDTH-1:0] c_TAPS = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_NZ   = NONZERO_SEED[WIDTH-1:0];
    localparam logic [7:0]       c_LAST = 8'(MIX_ROUNDS - 1);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_lfsr, w_lfsr_next;
    logic [7:0]       r_rounds, w_rounds_next;
    logic [WIDTH-1:0] r_seed, w_seed_next;
    logic             r_seed_valid, w_valid_next;
    logic [WIDTH-1:0] w_basis;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_mix;

    seedgen_basis #(
        .WIDTH    (WIDTH)
    ) u_basis (
        .clk      (clk),
        .reset    (reset),
        .restart  (rst_seedgen),
        .basis    (w_basis),
        .rollover (rollover)
    );

    assign w_step = WIDTH'(lfsr_step(64'(r_lfsr), 64'(c_TAPS)));

`ifdef SEEDGEN_ENTROPY_EN
    logic             r_ent_meta, r_ent_sync;
    logic [WIDTH-1:0] w_mix_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ent_meta <= 1'b0;
            r_ent_sync <= 1'b0;
        end else begin
            r_ent_meta <= entropy_in;
            r_ent_sync <= r_ent_meta;
        end
    end

    assign w_mix_raw = w_step ^ {r_ent_sync, {(WIDTH-1){1'b0}}};
    assign w_mix     = (w_mix_raw == '0) ? c_NZ : w_mix_raw;
`else
    assign w_mix = w_step;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lfsr       <= '0;
            r_rounds     <= '0;
            r_seed       <= '0;
            r_seed_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_lfsr       <= w_lfsr_next;
            r_rounds     <= w_rounds_next;
            r_seed       <= w_seed_next;
            r_seed_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_lfsr_next   = r_lfsr;
        w_rounds_next = r_rounds;
        w_seed_next   = r_seed;
        w_valid_next  = r_seed_valid;
        if (rst_seedgen) begin
            w_state_next = IDLE;
            w_valid_next = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (seed_req) begin
                        w_lfsr_next   = (w_basis == '0) ? c_NZ : w_basis;
                        w_rounds_next = '0;
                        w_state_next  = MIX;
                    end
                end
                MIX: begin
                    w_lfsr_next   = w_mix;
                    w_rounds_next = r_rounds + 8'd1;
                    if (r_rounds == c_LAST) begin
                        w_seed_next  = w_mix;
                        w_valid_next = 1'b1;
                        w_state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (seed_ack) begin
                        w_valid_next = 1'b0;
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign seed       = r_seed;
    assign seed_valid = r_seed_valid;
    assign busy       = (r_state == MIX);

endmodule

`default_nettype wire
